// File: rtl/arm_ir_pipeline_pkg.sv
// Shared ARM instruction-pipeline definitions: prefetch FIFO defaults,
// slot field widths and the slot record carried by FIFO entries, IR1 and IR2.
package arm_ir_pipeline_pkg;

   localparam int          DEPTH_DEFAULT       = 2;
   localparam logic [31:0] BUBBLE_WORD_DEFAULT = 32'h0000_0000;

   localparam int WORD_W = 32;
   localparam int SLOT_W = WORD_W + 2;   // word + valid + pabort

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic              valid;
      logic              pabort;
   } slot_t;

   // An empty slot: carries the bubble word, never valid, never aborted.
   function automatic slot_t make_bubble(input logic [WORD_W-1:0] bubble_word);
      slot_t s;
      s.word   = bubble_word;
      s.valid  = 1'b0;
      s.pabort = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/arm_prefetch_fifo.sv
// Prefetch FIFO for opcode words.
// Ports:
//   sysclk, RESET      : clock, asynchronous active-high reset
//   flush              : empties the FIFO and clears the overflow flag
//   push, push_slot    : write request and slot {word, valid, pabort}
//   pop                : remove the head entry (ignored when empty)
//   head               : head slot, or a bubble when empty
//   empty, full        : occupancy decodes (registered count only)
//   overflow           : sticky, a push arrived while full with no pop
module arm_prefetch_fifo
   import arm_ir_pipeline_pkg::*;
#(
   parameter int          DEPTH       = DEPTH_DEFAULT,
   parameter logic [31:0] BUBBLE_WORD = BUBBLE_WORD_DEFAULT
) (
   input  logic              sysclk,
   input  logic              RESET,
   input  logic              flush,
   input  logic              push,
   input  logic [SLOT_W-1:0] push_slot,
   input  logic              pop,
   output logic [SLOT_W-1:0] head,
   output logic              empty,
   output logic              full,
   output logic              overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [SLOT_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              do_pop;
   logic              do_push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? SLOT_W'(make_bubble(BUBBLE_WORD)) : mem[rd_ptr];

   always_ff @(posedge sysclk or posedge RESET) begin
      if (RESET) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: head is masked to a bubble while empty.
   always_ff @(posedge sysclk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_slot;
   end

endmodule

// File: rtl/arm_ir_pipeline.sv
// Instruction prefetch and IR1/IR2 decode registers ahead of armcontroller.
// Ports:
//   sysclk, RESET        : clock, asynchronous active-high reset
//   DIN, IFETCH_Done     : opcode word and its completion strobe
//   ABORT                : prefetch abort attached to the fetched word
//   nSTALL               : 0 freezes IR1/IR2
//   ir1_zero, ir2_zero   : force a bubble into IR1 / IR2
//   ld_ir2_mult          : capture ir2_bus into ir2_mult_bus
//   Flush                : empty FIFO, IR1 and IR2
//   ir2_bus, ir2_mult_bus, ir1_valid, ir2_valid, ir2_pabort : pipeline state
//   Fetch_Hold           : FIFO full, memory must not start a new fetch
//   Fetch_Overflow       : sticky, a fetch was dropped because FIFO was full
//
// Handshake: IFETCH_Done is a single-cycle valid with no ready; the word is
// accepted on that edge unless the FIFO is full. Fetch_Hold is the only
// back-pressure and memory is expected to honour it before starting a fetch.
module arm_ir_pipeline
   import arm_ir_pipeline_pkg::*;
#(
   parameter int          DEPTH       = DEPTH_DEFAULT,
   parameter logic [31:0] BUBBLE_WORD = BUBBLE_WORD_DEFAULT
) (
   input  logic        sysclk,
   input  logic        RESET,
   input  logic [31:0] DIN,
   input  logic        IFETCH_Done,
   input  logic        ABORT,
   input  logic        nSTALL,
   input  logic        ir1_zero,
   input  logic        ir2_zero,
   input  logic        ld_ir2_mult,
   input  logic        Flush,
   output logic [31:0] ir2_bus,
   output logic [31:0] ir2_mult_bus,
   output logic        ir1_valid,
   output logic        ir2_valid,
   output logic        ir2_pabort,
   output logic        Fetch_Hold,
   output logic        Fetch_Overflow
);

   slot_t             ir1;
   slot_t             ir2;
   slot_t             ir1_next;
   slot_t             ir2_next;
   slot_t             din_slot;
   slot_t             bubble;
   logic [SLOT_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_pop;
   logic              fifo_push;
   logic              bypass;

   assign bubble   = make_bubble(BUBBLE_WORD);
   assign din_slot = '{word: DIN, valid: 1'b1, pabort: ABORT};

   // The FIFO always feeds IR1 ahead of DIN so program order is kept;
   // DIN goes straight to IR1 only when nothing is buffered.
   assign fifo_pop  = nSTALL && !fifo_empty && !Flush;
   assign bypass    = nSTALL && fifo_empty && IFETCH_Done;
   assign fifo_push = IFETCH_Done && !bypass && !Flush;

   arm_prefetch_fifo #(
      .DEPTH       (DEPTH),
      .BUBBLE_WORD (BUBBLE_WORD)
   ) u_fifo (
      .sysclk    (sysclk),
      .RESET     (RESET),
      .flush     (Flush),
      .push      (fifo_push),
      .push_slot (din_slot),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .overflow  (Fetch_Overflow)
   );

   always_comb begin
      ir1_next = ir1;
      ir2_next = ir2;
      if (Flush) begin
         ir1_next = bubble;
         ir2_next = bubble;
      end else if (nSTALL) begin
         ir2_next = ir2_zero ? bubble : ir1;
         // The popped or bypassed word is consumed even when ir1_zero drops it.
         if (ir1_zero)          ir1_next = bubble;
         else if (!fifo_empty)  ir1_next = slot_t'(fifo_head);
         else if (IFETCH_Done)  ir1_next = din_slot;
         else                   ir1_next = bubble;
      end else begin
         if (ir1_zero) ir1_next = bubble;
         if (ir2_zero) ir2_next = bubble;
      end
   end

   always_ff @(posedge sysclk or posedge RESET) begin
      if (RESET) begin
         ir1          <= bubble;
         ir2          <= bubble;
         ir2_mult_bus <= '0;
      end else begin
         ir1 <= ir1_next;
         ir2 <= ir2_next;
         if (ld_ir2_mult) ir2_mult_bus <= ir2.word;
      end
   end

   assign ir2_bus    = ir2.word;
   assign ir2_valid  = ir2.valid;
   assign ir2_pabort = ir2.pabort;
   assign ir1_valid  = ir1.valid;
   assign Fetch_Hold = fifo_full;

endmodule

// File: tb/tb_arm_ir_pipeline.sv
module tb_arm_ir_pipeline;

   logic        sysclk;
   logic        RESET;
   logic [31:0] DIN;
   logic        IFETCH_Done;
   logic        ABORT;
   logic        nSTALL;
   logic        ir1_zero;
   logic        ir2_zero;
   logic        ld_ir2_mult;
   logic        Flush;
   logic [31:0] ir2_bus;
   logic [31:0] ir2_mult_bus;
   logic        ir1_valid;
   logic        ir2_valid;
   logic        ir2_pabort;
   logic        Fetch_Hold;
   logic        Fetch_Overflow;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   arm_ir_pipeline dut (
      .sysclk         (sysclk),
      .RESET          (RESET),
      .DIN            (DIN),
      .IFETCH_Done    (IFETCH_Done),
      .ABORT          (ABORT),
      .nSTALL         (nSTALL),
      .ir1_zero       (ir1_zero),
      .ir2_zero       (ir2_zero),
      .ld_ir2_mult    (ld_ir2_mult),
      .Flush          (Flush),
      .ir2_bus        (ir2_bus),
      .ir2_mult_bus   (ir2_mult_bus),
      .ir1_valid      (ir1_valid),
      .ir2_valid      (ir2_valid),
      .ir2_pabort     (ir2_pabort),
      .Fetch_Hold     (Fetch_Hold),
      .Fetch_Overflow (Fetch_Overflow)
   );

   // clock / reset
   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // one clock edge, then settle away from the edge
   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] w, input logic ab);
      DIN         = w;
      IFETCH_Done = 1'b1;
      ABORT       = ab;
   endtask

   task automatic idle_fetch();
      IFETCH_Done = 1'b0;
      ABORT       = 1'b0;
      DIN         = 32'h0;
   endtask

   initial begin
      RESET = 1'b1; DIN = '0; IFETCH_Done = 0; ABORT = 0; nSTALL = 1;
      ir1_zero = 0; ir2_zero = 0; ld_ir2_mult = 0; Flush = 0;
      step(); step();
      chk("rst_ir2_bus",   ir2_bus, 32'h0);
      chk("rst_mult",      ir2_mult_bus, 32'h0);
      chk("rst_ir1_valid", {31'b0, ir1_valid}, 32'h0);
      chk("rst_ir2_valid", {31'b0, ir2_valid}, 32'h0);
      chk("rst_pabort",    {31'b0, ir2_pabort}, 32'h0);
      chk("rst_hold",      {31'b0, Fetch_Hold}, 32'h0);
      chk("rst_ovf",       {31'b0, Fetch_Overflow}, 32'h0);
      RESET = 1'b0;

      // bypass: fetch at edge k, IR2 after edge k+1
      fetch(32'he6910002, 1'b0); step();
      chk("byp_ir1_valid", {31'b0, ir1_valid}, 32'h1);
      chk("byp_ir2_early", {31'b0, ir2_valid}, 32'h0);
      idle_fetch(); step();
      chk("byp_ir2_bus",   ir2_bus, 32'he6910002);
      chk("byp_ir2_valid", {31'b0, ir2_valid}, 32'h1);
      step();
      chk("byp_drain",     {31'b0, ir2_valid}, 32'h0);

      // stall buffering and overflow
      nSTALL = 0;
      fetch(32'h11111111, 1'b0); exp_q.push_back(32'h11111111); step();
      fetch(32'h22222222, 1'b0); exp_q.push_back(32'h22222222); step();
      chk("stall_hold",  {31'b0, Fetch_Hold}, 32'h1);
      chk("stall_count", 32'(dut.u_fifo.count), 32'd2);
      chk("stall_noovf", {31'b0, Fetch_Overflow}, 32'h0);
      fetch(32'h33333333, 1'b0); step();
      chk("stall_ovf",   {31'b0, Fetch_Overflow}, 32'h1);
      idle_fetch(); nSTALL = 1; step();
      chk("rel_count",   32'(dut.u_fifo.count), 32'd1);
      chk("rel_hold",    {31'b0, Fetch_Hold}, 32'h0);
      step();
      chk("order_first",  ir2_bus, exp_q.pop_front());
      step();
      chk("order_second", ir2_bus, exp_q.pop_front());
      chk("ovf_sticky",   {31'b0, Fetch_Overflow}, 32'h1);

      // ir1_zero discards FIFO head C, D follows
      nSTALL = 0;
      fetch(32'hcccc0001, 1'b0); step();
      fetch(32'hdddd0002, 1'b0); step();
      idle_fetch(); nSTALL = 1; ir1_zero = 1; step();
      chk("z1_ir1_valid", {31'b0, ir1_valid}, 32'h0);
      chk("z1_count",     32'(dut.u_fifo.count), 32'd1);
      ir1_zero = 0; step();
      step();
      chk("z1_next_word", ir2_bus, 32'hdddd0002);
      // ir2_zero with a valid word in IR1
      fetch(32'heeee0003, 1'b0); step();
      chk("z2_ir1_loaded", {31'b0, ir1_valid}, 32'h1);
      idle_fetch(); ir2_zero = 1; step();
      chk("z2_ir2_bus",   ir2_bus, 32'h0);
      chk("z2_ir2_valid", {31'b0, ir2_valid}, 32'h0);
      ir2_zero = 0;

      // mult hold load
      fetch(32'he1054096, 1'b0); step();
      idle_fetch(); step();
      chk("mult_ir2", ir2_bus, 32'he1054096);
      ld_ir2_mult = 1; step();
      ld_ir2_mult = 0;
      chk("mult_load", ir2_mult_bus, 32'he1054096);

      // flush with concurrent fetch and two buffered words
      fetch(32'h77770001, 1'b0); step();
      nSTALL = 0;
      fetch(32'hf0000001, 1'b0); step();
      fetch(32'hf0000002, 1'b0); step();
      chk("fl_pre_hold",  {31'b0, Fetch_Hold}, 32'h1);
      chk("fl_pre_ir1",   {31'b0, ir1_valid}, 32'h1);
      chk("fl_pre_ovf",   {31'b0, Fetch_Overflow}, 32'h1);
      Flush = 1; fetch(32'hf0000003, 1'b0); step();
      Flush = 0;
      chk("fl_count",     32'(dut.u_fifo.count), 32'd0);
      chk("fl_hold",      {31'b0, Fetch_Hold}, 32'h0);
      chk("fl_ir1",       {31'b0, ir1_valid}, 32'h0);
      chk("fl_ir2",       {31'b0, ir2_valid}, 32'h0);
      chk("fl_ovf",       {31'b0, Fetch_Overflow}, 32'h0);
      chk("fl_mult",      ir2_mult_bus, 32'he1054096);
      idle_fetch(); nSTALL = 1; step();
      chk("fl_discard",   {31'b0, ir1_valid}, 32'h0);

      // three words stream through, mult copy holds
      fetch(32'ha0000001, 1'b0); step();
      fetch(32'ha0000002, 1'b0); step();
      chk("stream_w1", ir2_bus, 32'ha0000001);
      fetch(32'ha0000003, 1'b0); step();
      chk("stream_w2", ir2_bus, 32'ha0000002);
      idle_fetch(); step();
      chk("stream_w3", ir2_bus, 32'ha0000003);
      chk("mult_held", ir2_mult_bus, 32'he1054096);

      // prefetch abort tag follows the word into IR2 only
      step();
      fetch(32'habcd0005, 1'b1); step();
      chk("ab_not_yet", {31'b0, ir2_pabort}, 32'h0);
      idle_fetch(); step();
      chk("ab_word",   ir2_bus, 32'habcd0005);
      chk("ab_pabort", {31'b0, ir2_pabort}, 32'h1);
      step();
      chk("ab_gone",   {31'b0, ir2_pabort}, 32'h0);

      // asynchronous reset mid-stall
      fetch(32'h55550001, 1'b0); step();
      idle_fetch(); step();
      nSTALL = 0;
      fetch(32'h55550002, 1'b0); step();
      fetch(32'h55550003, 1'b0); step();
      chk("ar_pre_hold", {31'b0, Fetch_Hold}, 32'h1);
      chk("ar_pre_ir2",  {31'b0, ir2_valid}, 32'h1);
      RESET = 1'b1;
      #1;
      chk("ar_ir2_bus", ir2_bus, 32'h0);
      chk("ar_mult",    ir2_mult_bus, 32'h0);
      chk("ar_ir2",     {31'b0, ir2_valid}, 32'h0);
      chk("ar_ir1",     {31'b0, ir1_valid}, 32'h0);
      chk("ar_hold",    {31'b0, Fetch_Hold}, 32'h0);
      chk("ar_ovf",     {31'b0, Fetch_Overflow}, 32'h0);
      nSTALL = 1; fetch(32'h55550004, 1'b0); step();
      chk("ar_nocapture", {31'b0, ir1_valid}, 32'h0);
      RESET = 1'b0; idle_fetch(); step();
      chk("ar_after",     {31'b0, ir1_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
